// File: rtl/piece_queue.sv
// rtl/piece_queue.sv - tetromino preview FIFO with prefetch, spawn handshake and once-per-piece hold slot
module piece_queue #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    output logic               gen_req,
    input  logic [2:0]         gen_idx,
    input  logic               spawn_req,
    output logic               spawn_ack,
    input  logic               hold_req,
    output logic               hold_ack,
    output logic               active_valid,
    output logic [2:0]         active_idx,
    output logic               hold_valid,
    output logic [2:0]         hold_idx,
    output logic [3*DEPTH-1:0] preview,
    output logic [CNT_W-1:0]   queue_count,
    output logic               ready
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic             started;
    logic             hold_used;
    logic [2:0]       fifo     [DEPTH];
    logic [2:0]       fifo_nxt [DEPTH];
    logic [2:0]       gen_clean;
    logic [2:0]       head;
    logic             not_empty;
    logic             hold_ok;
    logic             spawn_ok;
    logic             pop;
    logic             push;
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_nxt;

    assign gen_req   = started && (queue_count < FULL);
    assign push      = gen_req;
    assign gen_clean = (gen_idx == 3'd7) ? 3'd0 : gen_idx;
    assign head      = fifo[0];
    assign not_empty = (queue_count != '0);
    assign ready     = (queue_count == FULL);

    // Hold wins over spawn; an empty hold slot needs a queued piece to replace the active one.
    assign hold_ok   = hold_req && active_valid && !hold_used && (hold_valid || not_empty);
    assign spawn_ok  = spawn_req && not_empty && !hold_ok;
    assign pop       = spawn_ok || (hold_ok && !hold_valid);
    assign wr_ptr    = queue_count - CNT_W'(pop);
    assign count_nxt = queue_count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fifo_nxt[i] = fifo[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                fifo_nxt[i] = fifo[i+1];
            end
            fifo_nxt[DEPTH-1] = 3'd0;
        end
        // The push lands at the tail as it stands after any same-edge shift.
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr == CNT_W'(i))) begin
                fifo_nxt[i] = gen_clean;
            end
        end
    end

    always_comb begin
        preview = '0;
        for (int i = 0; i < DEPTH; i++) begin
            preview[3*i +: 3] = fifo[i];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            started      <= 1'b0;
            hold_used    <= 1'b0;
            queue_count  <= '0;
            spawn_ack    <= 1'b0;
            hold_ack     <= 1'b0;
            active_valid <= 1'b0;
            active_idx   <= 3'd0;
            hold_valid   <= 1'b0;
            hold_idx     <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= 3'd0;
            end
        end else begin
            started     <= 1'b1;
            queue_count <= count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= fifo_nxt[i];
            end
            spawn_ack <= spawn_ok || hold_ok;
            hold_ack  <= hold_ok;
            if (hold_ok) begin
                hold_used  <= 1'b1;
                hold_valid <= 1'b1;
                hold_idx   <= active_idx;
                active_idx <= hold_valid ? hold_idx : head;
            end else if (spawn_ok) begin
                active_idx   <= head;
                active_valid <= 1'b1;
                hold_used    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_piece_queue.sv
// tb/tb_piece_queue.sv - directed self-checking bench for piece_queue
module tb_piece_queue;

    logic       Clk;
    logic       Reset;
    logic       gen_req;
    logic [2:0] gen_idx;
    logic       spawn_req;
    logic       spawn_ack;
    logic       hold_req;
    logic       hold_ack;
    logic       active_valid;
    logic [2:0] active_idx;
    logic       hold_valid;
    logic [2:0] hold_idx;
    logic [8:0] preview;
    logic [1:0] queue_count;
    logic       ready;

    int checks;
    int failures;

    logic [2:0] gen_list [32];
    logic [4:0] gen_ptr;
    logic [4:0] seg_base;

    piece_queue #(.DEPTH(3), .CNT_W(2)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .gen_req      (gen_req),
        .gen_idx      (gen_idx),
        .spawn_req    (spawn_req),
        .spawn_ack    (spawn_ack),
        .hold_req     (hold_req),
        .hold_ack     (hold_ack),
        .active_valid (active_valid),
        .active_idx   (active_idx),
        .hold_valid   (hold_valid),
        .hold_idx     (hold_idx),
        .preview      (preview),
        .queue_count  (queue_count),
        .ready        (ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Generator stub: walks a scripted list, restarting at seg_base on every reset.
    assign gen_idx = gen_list[gen_ptr];
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) gen_ptr <= seg_base;
        else if (gen_req) gen_ptr <= gen_ptr + 5'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        for (int i = 0; i < 32; i++) gen_list[i] = 3'd0;
        gen_list[0]  = 3'd5; gen_list[1]  = 3'd2; gen_list[2]  = 3'd7; gen_list[3]  = 3'd4;
        gen_list[10] = 3'd5; gen_list[11] = 3'd3;
        gen_list[20] = 3'd1; gen_list[21] = 3'd3; gen_list[22] = 3'd6; gen_list[23] = 3'd7;
        gen_list[24] = 3'd2; gen_list[25] = 3'd4;
        seg_base  = 5'd0;
        spawn_req = 1'b0;
        hold_req  = 1'b0;
        Reset     = 1'b1;
        #1 Reset  = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_gen_req", gen_req, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_preview", preview, 0);
        chk("rst_outputs", {spawn_ack, hold_ack, active_valid, active_idx, hold_valid, hold_idx, ready}, 0);

        // Fill from 5,2,7 after release
        Reset = 1'b1;
        #1 chk("fill_pre_gen_req", gen_req, 0);
        step(); chk("fill_e1", {gen_req, queue_count}, {1'b1, 2'd0});
        step(); chk("fill_e2", {gen_req, queue_count}, {1'b1, 2'd1});
        step(); chk("fill_e3", {gen_req, queue_count}, {1'b1, 2'd2});
        step(); chk("fill_e4", {gen_req, queue_count, ready}, {1'b0, 2'd3, 1'b1});
        chk("fill_preview", preview, 9'h015);

        // Spawn from full queue, refill with 4
        spawn_req = 1'b1;
        step();
        chk("spawn_ack", {spawn_ack, hold_ack, active_valid, active_idx}, {1'b1, 1'b0, 1'b1, 3'd5});
        spawn_req = 1'b0;
        step();
        chk("spawn_after_ack", {spawn_ack, active_idx}, {1'b0, 3'd5});
        chk("spawn_refill", {queue_count, preview}, {2'd3, 9'h102});

        // Reset mid-fill at count 1 with spawn pending
        seg_base  = 5'd10;
        Reset     = 1'b0;
        spawn_req = 1'b1;
        step();
        Reset = 1'b1;
        step();
        step();
        chk("midfill_count1", {queue_count, preview, spawn_ack}, {2'd1, 9'h005, 1'b0});
        seg_base = 5'd20;
        #1 Reset = 1'b0;
        #1;
        chk("async_rst_gen_req", gen_req, 0);
        chk("async_rst_state", {queue_count, preview, active_valid, active_idx, spawn_ack, ready}, 0);
        @(negedge Clk);
        Reset = 1'b1;

        // Restart with spawn still pending: served the edge after count reaches 1
        step(); chk("restart_e1", {gen_req, queue_count, spawn_ack}, {1'b1, 2'd0, 1'b0});
        step(); chk("restart_e2", {queue_count, spawn_ack}, {2'd1, 1'b0});
        step();
        chk("prefill_spawn", {spawn_ack, active_valid, active_idx}, {1'b1, 1'b1, 3'd1});
        spawn_req = 1'b0;
        step();
        step();
        chk("prefill_queue", {queue_count, preview}, {2'd3, 9'h033});

        // Hold into empty slot, then a rejected second hold
        hold_req = 1'b1;
        step();
        chk("hold1_acks", {hold_ack, spawn_ack}, 2'b11);
        chk("hold1_state", {active_idx, hold_valid, hold_idx, queue_count, preview},
            {3'd3, 1'b1, 3'd1, 2'd2, 9'h006});
        hold_req = 1'b0;
        step();
        chk("hold1_refill", {hold_ack, spawn_ack, queue_count, preview}, {2'b00, 2'd3, 9'h086});
        hold_req = 1'b1;
        step();
        chk("hold2_reject", {hold_ack, spawn_ack, active_idx, hold_idx, queue_count, preview},
            {2'b00, 3'd3, 3'd1, 2'd3, 9'h086});
        hold_req = 1'b0;

        // Normal spawn clears hold_used; then hold+spawn together swaps once
        spawn_req = 1'b1;
        step();
        chk("spawn2", {spawn_ack, hold_ack, active_idx, hold_idx, queue_count}, {2'b10, 3'd6, 3'd1, 2'd2});
        spawn_req = 1'b0;
        step();
        chk("spawn2_refill", {queue_count, preview}, {2'd3, 9'h110});
        spawn_req = 1'b1;
        hold_req  = 1'b1;
        step();
        chk("swap_acks", {hold_ack, spawn_ack}, 2'b11);
        chk("swap_state", {active_idx, hold_valid, hold_idx, queue_count, preview},
            {3'd1, 1'b1, 3'd6, 2'd3, 9'h110});
        spawn_req = 1'b0;
        hold_req  = 1'b0;
        step();
        chk("swap_single_ack", {hold_ack, spawn_ack, active_idx, queue_count, preview},
            {2'b00, 3'd1, 2'd3, 9'h110});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
